// File: rtl/pipeline_latealu.sv
// LateALU responder: registered srl/sra results, HI/LO moves and signed multiply.
// Define LATEALU_FAST_MULT_EN for a single-cycle multiply; default is a 32-step shift-add.
module pipeline_latealu (
  input  logic        clk,
  input  logic        rst,
  input  logic        latealu_enable,
  input  logic [5:0]  latealu_op,
  input  logic [31:0] latealu_a0,
  input  logic [31:0] latealu_a1,
  input  logic [4:0]  rd_index_in,
  output logic [4:0]  rd_index_out,
  output logic [31:0] rd_value_out,
  output logic        rd_valid,
  output logic [31:0] mult_hi,
  output logic [31:0] mult_lo,
  output logic        busy,
  output logic        bad_op
);

  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_SRA  = 6'b000011;
  localparam logic [5:0] OP_MULT = 6'b000100;
  localparam logic [5:0] OP_MTHI = 6'b000101;
  localparam logic [5:0] OP_MTLO = 6'b000110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Two's-complement magnitude; 0x80000000 yields unsigned 2^31.
  function automatic logic [31:0] magnitude(input logic [31:0] v);
    if (v[31]) begin
      magnitude = ~v + 32'd1;
    end else begin
      magnitude = v;
    end
  endfunction

  function automatic logic [31:0] shift_value(input logic [5:0] op, input logic [31:0] v,
                                              input logic [4:0] amt);
    if (op == OP_SRA) begin
      shift_value = $signed(v) >>> amt;
    end else begin
      shift_value = v >> amt;
    end
  endfunction

  logic        shift_req_s;
  logic        mult_req_s;
  logic        mthi_req_s;
  logic        mtlo_req_s;
  logic        undef_req_s;

  state_t      state_r;
  logic        neg_r;
  logic        busy_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [63:0] product_s;
  logic [63:0] fix_value_s;

  logic        rd_valid_r;
  logic [4:0]  rd_index_r;
  logic [31:0] rd_value_r;
  logic        bad_op_r;

  // Request decode.
  always_comb begin
    shift_req_s = 1'b0;
    mult_req_s  = 1'b0;
    mthi_req_s  = 1'b0;
    mtlo_req_s  = 1'b0;
    undef_req_s = 1'b0;
    if (latealu_enable) begin
      case (latealu_op)
        OP_SRL, OP_SRA: shift_req_s = 1'b1;
        OP_MULT:        mult_req_s  = 1'b1;
        OP_MTHI:        mthi_req_s  = 1'b1;
        OP_MTLO:        mtlo_req_s  = 1'b1;
        default:        undef_req_s = 1'b1;
      endcase
    end else begin
      undef_req_s = 1'b0;
    end
  end

`ifdef LATEALU_FAST_MULT_EN
  logic [31:0] mag_a_r;
  logic [31:0] mag_b_r;

  // Magnitude product straight from the captured operands.
  always_comb begin
    product_s = {32'd0, mag_a_r} * {32'd0, mag_b_r};
  end

  // Single-cycle multiply FSM plus HI/LO ownership.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      mag_a_r <= 32'd0;
      mag_b_r <= 32'd0;
      neg_r   <= 1'b0;
      busy_r  <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (mult_req_s) begin
            state_r <= FIX;
            mag_a_r <= magnitude(latealu_a0);
            mag_b_r <= magnitude(latealu_a1);
            neg_r   <= latealu_a0[31] ^ latealu_a1[31];
            busy_r  <= 1'b1;
          end else if (mthi_req_s) begin
            hi_r <= latealu_a0;
          end else if (mtlo_req_s) begin
            lo_r <= latealu_a0;
          end
        end
        FIX: begin
          {hi_r, lo_r} <= fix_value_s;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end
`else
  logic [4:0]  count_r;
  logic [63:0] acc_r;
  logic [63:0] mcand_r;
  logic [31:0] mplier_r;

  // Accumulated partial products form the magnitude product.
  always_comb begin
    product_s = acc_r;
  end

  // Iterative shift-add multiply FSM plus HI/LO ownership.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      count_r  <= 5'd0;
      acc_r    <= 64'd0;
      mcand_r  <= 64'd0;
      mplier_r <= 32'd0;
      neg_r    <= 1'b0;
      busy_r   <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (mult_req_s) begin
            state_r  <= MUL;
            count_r  <= 5'd0;
            acc_r    <= 64'd0;
            mcand_r  <= {32'd0, magnitude(latealu_a0)};
            mplier_r <= magnitude(latealu_a1);
            neg_r    <= latealu_a0[31] ^ latealu_a1[31];
            busy_r   <= 1'b1;
          end else if (mthi_req_s) begin
            hi_r <= latealu_a0;
          end else if (mtlo_req_s) begin
            lo_r <= latealu_a0;
          end
        end
        MUL: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          if (count_r == 5'd31) begin
            state_r <= FIX;
          end else begin
            count_r <= count_r + 5'd1;
          end
        end
        FIX: begin
          {hi_r, lo_r} <= fix_value_s;
          busy_r       <= 1'b0;
          count_r      <= 5'd0;
          state_r      <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          count_r <= 5'd0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end
`endif

  // Sign correction of the magnitude product.
  always_comb begin
    if (neg_r) begin
      fix_value_s = ~product_s + 64'd1;
    end else begin
      fix_value_s = product_s;
    end
  end

  // Shift result and bad-op pulse, independent of the multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      rd_index_r <= 5'd0;
      rd_value_r <= 32'd0;
      bad_op_r   <= 1'b0;
    end else begin
      bad_op_r <= undef_req_s;
      if (shift_req_s) begin
        rd_valid_r <= 1'b1;
        rd_index_r <= rd_index_in;
        rd_value_r <= shift_value(latealu_op, latealu_a0, latealu_a1[4:0]);
      end else begin
        rd_valid_r <= 1'b0;
        rd_index_r <= 5'd0;
        rd_value_r <= 32'd0;
      end
    end
  end

  assign rd_valid     = rd_valid_r;
  assign rd_index_out = rd_index_r;
  assign rd_value_out = rd_value_r;
  assign mult_hi      = hi_r;
  assign mult_lo      = lo_r;
  assign busy         = busy_r;
  assign bad_op       = bad_op_r;

endmodule

// File: tb/tb_pipeline_latealu.sv
// Directed plus randomized bench for pipeline_latealu against an arithmetic reference.
module tb_pipeline_latealu;

`ifdef LATEALU_FAST_MULT_EN
  localparam int BUSY_CYC = 1;
`else
  localparam int BUSY_CYC = 33;
`endif

  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_SRA  = 6'b000011;
  localparam logic [5:0] OP_MULT = 6'b000100;
  localparam logic [5:0] OP_MTHI = 6'b000101;
  localparam logic [5:0] OP_MTLO = 6'b000110;

  logic        clk;
  logic        rst;
  logic        en;
  logic [5:0]  op;
  logic [31:0] a0;
  logic [31:0] a1;
  logic [4:0]  rd_in;
  logic [4:0]  rd_index_out;
  logic [31:0] rd_value_out;
  logic        rd_valid;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic        busy;
  logic        bad_op;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  pipeline_latealu dut (
    .clk(clk), .rst(rst), .latealu_enable(en), .latealu_op(op),
    .latealu_a0(a0), .latealu_a1(a1), .rd_index_in(rd_in),
    .rd_index_out(rd_index_out), .rd_value_out(rd_value_out), .rd_valid(rd_valid),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .busy(busy), .bad_op(bad_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] rd);
    en = 1'b1; op = o; a0 = x; a1 = y; rd_in = rd;
  endtask

  task automatic idle_in();
    en = 1'b0; op = 6'd0; a0 = 32'd0; a1 = 32'd0; rd_in = 5'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
  endtask

  // Reference: full signed product.
  function automatic logic [63:0] ref_mult(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p;
  endfunction

  // Reference: divide-style shift with sign fill for sra.
  function automatic logic [31:0] ref_shift(input logic [5:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    int amt;
    logic [31:0] fill;
    amt = y % 32;
    fill = (o == OP_SRA && x[31]) ? ~(32'hFFFF_FFFF >> amt) : 32'd0;
    return (x >> amt) | fill;
  endfunction

  task automatic do_mult(input logic [31:0] x, input logic [31:0] y, input string tag);
    int n;
    logic [63:0] p;
    p = ref_mult(x, y);
    drive(OP_MULT, x, y, 5'd0);
    step();
    idle_in();
    chk({tag, "_busy_start"}, {63'd0, busy}, 64'd1);
    chk({tag, "_hold_hi"}, {32'd0, mult_hi}, {32'd0, exp_hi});
    wait_idle(n);
    chk({tag, "_busy_cycles"}, 64'(n), 64'(BUSY_CYC));
    exp_hi = p[63:32];
    exp_lo = p[31:0];
    chk({tag, "_hilo"}, {mult_hi, mult_lo}, p);
  endtask

  initial begin
    int n;
    logic [5:0]  rop;
    logic [31:0] rx;
    logic [31:0] ry;
    logic [4:0]  rrd;

    rst = 1'b1;
    idle_in();
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    step();
    step();
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("rst_rd_index", {59'd0, rd_index_out}, 64'd0);
    chk("rst_rd_value", {32'd0, rd_value_out}, 64'd0);
    chk("rst_hilo", {mult_hi, mult_lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_bad_op", {63'd0, bad_op}, 64'd0);
    rst = 1'b0;
    step();

    // Back-to-back sra then srl.
    drive(OP_SRA, 32'h8000_0000, 32'hFFFF_FFE4, 5'd7);
    step();
    chk("sra_valid", {63'd0, rd_valid}, 64'd1);
    chk("sra_value", {32'd0, rd_value_out}, 64'h0000_0000_F800_0000);
    chk("sra_index", {59'd0, rd_index_out}, 64'd7);
    drive(OP_SRL, 32'h8000_0000, 32'hFFFF_FFE4, 5'd9);
    step();
    idle_in();
    chk("srl_value", {32'd0, rd_value_out}, 64'h0000_0000_0800_0000);
    chk("srl_index", {59'd0, rd_index_out}, 64'd9);
    step();
    chk("shift_pulse_end", {63'd0, rd_valid}, 64'd0);
    chk("shift_index_clear", {59'd0, rd_index_out}, 64'd0);

    do_mult(32'hFFFF_FFF9, 32'd3, "mult_small");
    do_mult(32'h8000_0000, 32'h8000_0000, "mult_extreme");

    // Moves.
    drive(OP_MTHI, 32'h0000_1234, 32'd0, 5'd0);
    step();
    exp_hi = 32'h0000_1234;
    chk("mthi", {32'd0, mult_hi}, 64'h1234);
    drive(OP_MTLO, 32'hCAFE_F00D, 32'd0, 5'd0);
    step();
    idle_in();
    exp_lo = 32'hCAFE_F00D;
    chk("mtlo", {mult_hi, mult_lo}, 64'h0000_1234_CAFE_F00D);

    // mthi while busy is dropped; the product still lands.
    drive(OP_MULT, 32'hFFFF_FFF9, 32'd3, 5'd0);
    step();
    drive(OP_MTHI, 32'h0000_DEAD, 32'd0, 5'd0);
    step();
    idle_in();
    chk("mthi_busy_drop", {32'd0, mult_hi}, 64'h1234);
    wait_idle(n);
    chk("mthi_busy_prod", {mult_hi, mult_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    exp_hi = 32'hFFFF_FFFF;
    exp_lo = 32'hFFFF_FFEB;

    // Shift issued the cycle after a multiply is sampled.
    drive(OP_MULT, 32'd1000, 32'hFFFF_FFFE, 5'd0);
    step();
    drive(OP_SRL, 32'h0000_00F0, 32'd4, 5'd5);
    step();
    idle_in();
    chk("mid_shift_valid", {63'd0, rd_valid}, 64'd1);
    chk("mid_shift_value", {32'd0, rd_value_out}, 64'h0F);
    chk("mid_shift_index", {59'd0, rd_index_out}, 64'd5);
    wait_idle(n);
    chk("mid_shift_prod", {mult_hi, mult_lo}, ref_mult(32'd1000, 32'hFFFF_FFFE));
    exp_hi = mult_hi;
    exp_lo = mult_lo;

    // Reset partway through a multiply.
    drive(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0);
    step();
    idle_in();
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_hilo", {mult_hi, mult_lo}, 64'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    step();
    do_mult(32'h1234_5678, 32'h9ABC_DEF0, "mult_after_rst");

    // Undefined op.
    drive(6'h3F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    step();
    idle_in();
    chk("bad_op_pulse", {63'd0, bad_op}, 64'd1);
    chk("bad_op_no_rd", {63'd0, rd_valid}, 64'd0);
    chk("bad_op_hilo", {mult_hi, mult_lo}, {exp_hi, exp_lo});
    chk("bad_op_no_busy", {63'd0, busy}, 64'd0);
    step();
    chk("bad_op_end", {63'd0, bad_op}, 64'd0);

    // Randomized multiplies and shifts.
    for (int i = 0; i < 6; i++) begin
      do_mult($urandom, $urandom, "mult_rand");
    end
    for (int i = 0; i < 10; i++) begin
      rop = ($urandom_range(0, 1) == 0) ? OP_SRL : OP_SRA;
      rx  = $urandom;
      ry  = $urandom;
      rrd = 5'($urandom_range(0, 31));
      drive(rop, rx, ry, rrd);
      step();
      idle_in();
      chk("shift_rand_value", {32'd0, rd_value_out}, {32'd0, ref_shift(rop, rx, ry)});
      chk("shift_rand_index", {59'd0, rd_index_out}, {59'd0, rrd});
      chk("shift_rand_hilo", {mult_hi, mult_lo}, {exp_hi, exp_lo});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_latealu.md
# pipeline_latealu

Responder for the ALU stage's LateALU request interface: samples the registered `latealu_enable`/`op`/`a0`/`a1` bundle, executes logical and arithmetic right shifts, and handles signed multiply and HI/LO moves. It owns the architectural HI/LO registers that feed the ALU stage's `mfhi`/`mflo` path. It sits beside the ALU stage, with its shift result merged into the writeback path one cycle after issue. It provides `busy` so hazard logic can stall HI/LO consumers while a multiply is in flight.

## Interface
- No parameters.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `latealu_enable`  in  1  request valid, one cycle per request.
- `latealu_op`  in  6  operation code: 000010 srl, 000011 sra, 000100 mult, 000101 mthi, 000110 mtlo.
- `latealu_a0`  in  32  shift source / multiplicand / move value.
- `latealu_a1`  in  32  shift amount (bits [4:0] only) / multiplier.
- `rd_index_in`  in  5  destination register of a shift request.
- `rd_index_out`  out  5  destination of the shift result; 0 when no result.
- `rd_value_out`  out  32  shift result.
- `rd_valid`  out  1  `rd_value_out`/`rd_index_out` valid this cycle.
- `mult_hi`, `mult_lo`  out  32 each  architectural HI/LO.
- `busy`  out  1  a multiply is in progress; HI/LO not yet updated.
- `bad_op`  out  1  one-cycle pulse when an undefined op is requested.

## Operation
- A request is sampled at a rising edge when `latealu_enable`=1.
- Shifts:
  - srl gives `a0 >> a1[4:0]`; sra gives `$signed(a0) >>> a1[4:0]`. Bits [31:5] of `a1` are ignored.
  - Shifts are accepted even when `busy`=1.
- mthi/mtlo write `a0` into HI/LO.
  - Accepted only when `busy`=0.
  - A move request while busy is dropped. Upstream hazard logic guarantees this does not happen.
- mult (signed 32×32 → 64):
  - Accepted only when `busy`=0; a mult request while busy is dropped.
  - Operand handling: capture magnitudes |a0| and |a1| (0x80000000 is treated as unsigned 2^31), plus `neg` = a0[31]^a1[31].
  - Multiply the magnitudes unsigned, then negate the 64-bit product when `neg`=1.
  - Write {HI,LO} = product.
- Iterative FSM (default build):
  - IDLE: on accepted mult, go to MUL with count=0.
  - MUL: one shift-add step per cycle; go to FIX after count=31.
  - FIX: apply sign, write HI/LO, return to IDLE.
- Undefined op with enable=1: no state change; `bad_op`=1 for one cycle.
- HI/LO keep their old values throughout a multiply.

## Timing
- Reset values:
  - `rd_index_out`=0, `rd_value_out`=0, `rd_valid`=0.
  - `mult_hi`=`mult_lo`=0, `busy`=0, `bad_op`=0.
  - FSM=IDLE, count=0.
- Shift: request sampled at edge E0; `rd_valid`=1 with the result in the cycle after E0, for exactly one cycle.
- mthi/mtlo: sampled at E0; new HI/LO visible after E0.
- Iterative mult:
  - Sampled at E0; `busy`=1 after E0.
  - Steps at E1..E32; FIX at E33.
  - After E33: HI/LO hold the product and `busy`=0.
  - A new mult may be sampled at E34.
- Fast mult: sampled at E0; `busy`=1 after E0; HI/LO written and `busy`=0 after E1.
- Simultaneous shift and multiply completion: both complete in the same cycle, with no interaction.
- Reset asserted mid-multiply: abort at that edge; HI/LO=0, `busy`=0.
- `bad_op` behaves like a shift: registered, one-cycle pulse.

## Configuration
- `LATEALU_FAST_MULT_EN` defined:
  - Single-cycle multiply: `busy` is high for 1 cycle.
  - FSM collapses to IDLE/FIX; the magnitude product is computed combinationally from the captured operands.
- `LATEALU_FAST_MULT_EN` undefined: 32-step iterative multiplier as above; `busy` is high for 33 cycles.
- All other behaviour and every interface signal is identical in both builds.

## Test plan
- Shift results, both issued one cycle apart:
  - sra a0=0x80000000, a1=0xFFFFFFE4 (shift 4) → `rd_value_out`=0xF8000000 one cycle later.
  - srl with the same operands → 0x08000000.
- Small signed mult: a0=0xFFFFFFF9 (-7), a1=3.
  - `busy` high for 33 cycles (1 with the macro).
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Extreme mult: a0=a1=0x80000000 → HI=0x40000000, LO=0x00000000.
- Moves and dropped requests:
  - mthi 0x00001234, then mtlo 0xCAFEF00D → HI/LO updated one cycle after each.
  - mthi issued while `busy` → HI unchanged and the product still written.
- Shift during multiply: issue srl (0xF0, shift 4, rd=5) during a mult → `rd_valid` with 0x0F, `rd_index_out`=5; mult result still correct.
- Reset and bad op:
  - Assert `rst` at multiply step 10 → `busy`=0, HI=LO=0 next cycle.
  - Op 0x3F → `bad_op` pulses once; HI/LO unchanged.
